// File: rtl/scanline_fetch_arbiter_pkg.sv
// Shared video-path definitions for the scanline fetch arbiter.
//   - arb_state_t : arbiter state encoding (IDLE, FETCH, DRAIN, CPU_ISSUE, CPU_WAIT)
//   - VID_ADDR_W / VID_DATA_W : default main-memory address and data widths
//   - TILEMAP_BASE / TILEMAP_WORDS : tilemap region inside the scanline memory
//   - tilemap_addr() : scanline address for a fetch index (wraps at 256)
package scanline_fetch_arbiter_pkg;

  localparam int VID_ADDR_W    = 14;
  localparam int VID_DATA_W    = 12;
  localparam int SCMEM_ADDR_W  = 8;
  localparam int FETCH_IDX_W   = 8;
  localparam int TILEMAP_WORDS = 64;
  localparam logic [SCMEM_ADDR_W-1:0] TILEMAP_BASE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_CPU_ISSUE = 3'd3,
    ST_CPU_WAIT  = 3'd4
  } arb_state_t;

  // Scanline-memory address for word idx of a line fetch; 8-bit add wraps mod 256.
  function automatic logic [SCMEM_ADDR_W-1:0] tilemap_addr(
    input logic [SCMEM_ADDR_W-1:0] base,
    input logic [FETCH_IDX_W-1:0]  idx
  );
    return base + idx;
  endfunction

endpackage

// File: rtl/scanline_fetch_arbiter_fetch_delay_pipe.sv
// fetch_delay_pipe: STAGES-deep shift register carrying {valid, index} so the
// scanline write side lines up with main-memory read data.
//   clock, rst : clock, asynchronous active-low reset (clears valid bits only)
//   in_vld     : a fetch read address is being issued this cycle
//   in_idx     : word index of that read
//   out_vld    : read data for out_idx is on mem_rdata this cycle
//   out_idx    : word index delayed by STAGES cycles
module fetch_delay_pipe #(
  parameter int IDX_W  = 8,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [STAGES-1:0] vld_p;
  logic [IDX_W-1:0]  idx_p [STAGES];

  // Stage 0..STAGES-1: valid bits (control, reset)
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  // Stage 0..STAGES-1: index payload (data, only meaningful with its valid)
  always_ff @(posedge clock) begin
    idx_p[0] <= in_idx;
    for (int s = 1; s < STAGES; s++) begin
      idx_p[s] <= idx_p[s-1];
    end
  end

  assign out_vld = vld_p[STAGES-1];
  assign out_idx = idx_p[STAGES-1];

endmodule

// File: rtl/scanline_fetch_arbiter.sv
// scanline_fetch_arbiter: per-line fetch sequencer and main-memory port arbiter.
// A line_start strobe copies FETCH_LEN words from main memory (starting at
// row_base) into scanline memory at SCMEM_BASE and up. Between fetches, single
// CPU reads/writes are served on the same port. Fetch has strict priority.
//   clock, rst             : clock, asynchronous active-low reset
//   line_start, row_base   : fetch request strobe and main-memory start address
//   fetch_busy, fetch_done : fetch window active / pulse on final scanline write
//   overrun                : pulse one cycle after an ignored line_start
//   mem_addr/wdata/we      : main-memory port, mem_rdata returns MEM_LATENCY later
//   scmem_addr/wdata/we    : scanline-memory write port
//   cpu_req/we/addr/wdata  : CPU access request (held until cpu_ack)
//   cpu_ack, cpu_rdata     : completion pulse and read data
module scanline_fetch_arbiter
  import scanline_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W      = VID_ADDR_W,
  parameter int DATA_W      = VID_DATA_W,
  parameter int FETCH_LEN   = TILEMAP_WORDS,
  parameter logic [7:0] SCMEM_BASE = TILEMAP_BASE,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] row_base,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              overrun,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        scmem_addr,
  output logic [DATA_W-1:0] scmem_wdata,
  output logic              scmem_we,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [FETCH_IDX_W-1:0] LAST_IDX  = FETCH_IDX_W'(FETCH_LEN - 1);
  localparam logic [LAT_W-1:0]       LAST_WAIT = LAT_W'(MEM_LATENCY - 1);

  arb_state_t state, state_nxt;

  logic [FETCH_IDX_W-1:0] issue_cnt;
  logic [LAT_W-1:0]       wait_cnt;
  logic                   pending;
  logic                   overrun_q;
  logic [ADDR_W-1:0]      base_q;

  logic                   fetch_req;
  logic                   issue_last;
  logic                   wait_last;
  logic                   in_cpu;
  logic                   in_fetch_win;
  logic                   take_base;

  logic                   vld_pl;
  logic [FETCH_IDX_W-1:0] idx_pl;

  assign fetch_req    = line_start | pending;
  assign issue_last   = (issue_cnt == LAST_IDX);
  assign wait_last    = (wait_cnt == LAST_WAIT);
  assign in_cpu       = (state == ST_CPU_ISSUE) || (state == ST_CPU_WAIT);
  assign in_fetch_win = (state == ST_FETCH) || (state == ST_DRAIN);
  // A base is captured on the first accepted request only; a second strobe
  // while one is already pending must not disturb the latched address.
  assign take_base    = line_start && !pending && ((state == ST_IDLE) || in_cpu);

  // Next-state logic. A fetch that arrived during a CPU access starts right
  // after cpu_ack, skipping IDLE, so the CPU completion and the fetch are
  // back-to-back.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (fetch_req)    state_nxt = ST_FETCH;
        else if (cpu_req) state_nxt = ST_CPU_ISSUE;
      end
      ST_FETCH:     if (issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN:     if (wait_last)  state_nxt = ST_IDLE;
      ST_CPU_ISSUE: state_nxt = ST_CPU_WAIT;
      ST_CPU_WAIT: begin
        if (wait_last) state_nxt = fetch_req ? ST_FETCH : ST_IDLE;
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: state, counters, pending request, overrun pulse
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      wait_cnt  <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= (state == ST_FETCH) ? issue_cnt + 1'b1 : '0;
      wait_cnt  <= ((state == ST_CPU_WAIT) || (state == ST_DRAIN)) ? wait_cnt + 1'b1 : '0;
      pending   <= (state_nxt == ST_FETCH) ? 1'b0 : (pending | (line_start & in_cpu));
      overrun_q <= line_start & (in_fetch_win | (in_cpu & pending));
    end
  end

  // Fetch base address (data path, no reset; only read while fetching)
  always_ff @(posedge clock) begin
    if (take_base) base_q <= row_base;
  end

  // Read-issue to scanline-write alignment
  fetch_delay_pipe #(
    .IDX_W  (FETCH_IDX_W),
    .STAGES (MEM_LATENCY)
  ) u_delay (
    .clock   (clock),
    .rst     (rst),
    .in_vld  (state == ST_FETCH),
    .in_idx  (issue_cnt),
    .out_vld (vld_pl),
    .out_idx (idx_pl)
  );

  // Main-memory port mux; parked at zero when neither client owns it
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state == ST_FETCH) begin
      mem_addr = base_q + ADDR_W'(issue_cnt);
    end else if (state == ST_CPU_ISSUE) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end
  end

  // Scanline write side and CPU completion
  assign scmem_we    = vld_pl;
  assign scmem_addr  = vld_pl ? tilemap_addr(SCMEM_BASE, idx_pl) : '0;
  assign scmem_wdata = vld_pl ? mem_rdata : '0;
  assign fetch_done  = vld_pl && (idx_pl == LAST_IDX);
  assign fetch_busy  = in_fetch_win;
  assign overrun     = overrun_q;
  assign cpu_ack     = (state == ST_CPU_WAIT) && wait_last;
  assign cpu_rdata   = cpu_ack ? mem_rdata : '0;

endmodule
